tr_sequencer: RTL and testbench
===============================

TR_SEQUENCER -- requirements
Module: tr_sequencer

Interface
REQ-001 SHALL have parameters: RELAY_CYCLES, default 2000, relay settle time in clocks; MUTE_CYCLES, default 200, RX mute lead time; RAMP_DIV, default 16, clocks per tx_gain step; S_RATE_MAX, default 2, highest legal sample-rate code.
REQ-002 SHALL have ports: clock  in  1  system clock (2 MHz); reset  in  1  synchronous, active-low.
REQ-003 SHALL have ports: ptt_req  in  1  transmit request, synchronous to clock; cfg_rx_freq  in  32; cfg_tx_freq  in  32; cfg_s_rate  in  8; cfg_tx_level  in  8  (host-written config words).
REQ-004 SHALL have ports: rx_freq  out  32; tx_freq  out  32; s_rate  out  8; rx_mute  out  1; rx_flush  out  1  one-cycle decimator flush pulse; relay_tx  out  1  T/R relay drive; tx_en  out  1  DUC enable; tx_gain  out  8; busy  out  1  high when state is not RX.

Function
REQ-005 SHALL implement states RX, MUTE, RLY_ON, RAMP_UP, TX, RAMP_DN, RLY_OFF; all outputs registered.
REQ-006 RX: rx_mute=0, relay_tx=0, tx_en=0, tx_gain=0; ptt_req=1 -> MUTE next cycle, rx_mute=1, load counter MUTE_CYCLES.
REQ-007 MUTE: counter decrements; at 0 -> RLY_ON, relay_tx=1, load RELAY_CYCLES; ptt_req=0 in MUTE -> RX (relay never driven).
REQ-008 RLY_ON: at count 0 -> RAMP_UP, tx_en=1; ptt_req=0 in RLY_ON -> RLY_OFF, relay_tx=0, load RELAY_CYCLES.
REQ-009 RAMP_UP: tx_gain +1 every RAMP_DIV clocks until tx_gain == cfg_tx_level -> TX; target 0 -> TX next cycle; ptt_req=0 -> RAMP_DN from current gain.
REQ-010 TX: tx_gain tracks cfg_tx_level at ±1 per RAMP_DIV clocks; ptt_req=0 -> RAMP_DN.
REQ-011 RAMP_DN: tx_gain -1 every RAMP_DIV clocks; at 0 -> RLY_OFF, tx_en=0, relay_tx=0, load RELAY_CYCLES.
REQ-012 RLY_OFF: at count 0 -> RX, rx_mute=0; ptt_req ignored in RAMP_DN/RLY_OFF; if still high on RX entry, MUTE follows next cycle.
REQ-013 relay_tx SHALL never change state twice within fewer than RELAY_CYCLES clocks.
REQ-014 Counter 16 bits; parameter value 0 SHALL behave as 1 clock.
REQ-015 rx_freq SHALL load cfg_rx_freq with 1-cycle latency only in RX; changes in other states applied on RX entry.
REQ-016 tx_freq SHALL load cfg_tx_freq only in RX and MUTE; frozen RLY_ON through RLY_OFF.
REQ-017 In RX, cfg_s_rate != s_rate and <= S_RATE_MAX -> s_rate updated and rx_flush=1 for exactly one cycle; values > S_RATE_MAX ignored, s_rate held.
REQ-018 s_rate change pending outside RX SHALL apply, with flush pulse, on first RX cycle.
REQ-019 ptt_req rising and s_rate change in same RX cycle: both actions taken (MUTE entry plus flush).

Reset
REQ-020 reset low at a clock edge SHALL, in any state including mid-ramp or mid-relay-delay, force RX, rx_freq=tx_freq=7_000_000, s_rate=0, tx_gain=0, tx_en=0, relay_tx=0, rx_mute=0, rx_flush=0, busy=0, counters 0.

Configuration
REQ-021 Macro TR_RAMP_EN: defined -> gain ramping per REQ-009/010/011.
REQ-022 TR_RAMP_EN undefined -> RAMP_UP/RAMP_DN last one cycle each, tx_gain jumps to cfg_tx_level / 0, TX follows cfg_tx_level with 1-cycle latency; ramp logic absent.

Structure
REQ-023 Package tr_seq_pkg SHALL hold state enum, reset frequency constant 7_000_000, s_rate code constants (0=50 kHz, 1=100 kHz, 2=200 kHz).
REQ-024 Gain ramp (divider counter, ±1 step, compare) SHALL be sub-module gain_ramp, excluded when TR_RAMP_EN undefined.

Verification (RELAY_CYCLES=20, MUTE_CYCLES=4, RAMP_DIV=2)
REQ-025 ptt_req 1, cfg_tx_level=8 -> rx_mute next cycle, relay_tx +4, tx_en +20, tx_gain reaches 8 after 16 more cycles; ptt_req 0 -> gain to 0 in 16, relay_tx low, rx_mute low 20 later.
REQ-026 ptt_req pulse 2 cycles -> MUTE then RX, relay_tx stays 0.
REQ-027 ptt_req drops 5 cycles into RLY_ON -> relay_tx low, busy held 20 cycles; ptt_req re-raised meanwhile -> new MUTE only after RX.
REQ-028 In RX cfg_s_rate 0->2 -> s_rate=2, one rx_flush pulse; cfg_s_rate=5 -> no change, no pulse; change during TX -> flush on RX entry.
REQ-029 cfg_tx_freq changed during TX -> tx_freq unchanged until RX; reset asserted mid-RAMP_UP -> all outputs at reset values next cycle.
REQ-030 TR_RAMP_EN undefined build -> tx_gain steps 0->8 in one cycle.

Source files
------------

// File: rtl/tr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tr_seq_pkg
// Description : T/R sequencer shared types, reset constants and counter helper.
// Revision    : 1.0  initial release
// ============================================================================
package tr_seq_pkg;

    typedef enum logic [2:0] {
        ST_RX      = 3'd0,
        ST_MUTE    = 3'd1,
        ST_RLY_ON  = 3'd2,
        ST_RAMP_UP = 3'd3,
        ST_TX      = 3'd4,
        ST_RAMP_DN = 3'd5,
        ST_RLY_OFF = 3'd6
    } tr_state_e;

    localparam logic [31:0] C_RESET_FREQ  = 32'd7_000_000;
    localparam logic [7:0]  C_S_RATE_50K  = 8'd0;
    localparam logic [7:0]  C_S_RATE_100K = 8'd1;
    localparam logic [7:0]  C_S_RATE_200K = 8'd2;

    // Counters run load..0 inclusive, so a dwell of N clocks loads N-1 (0 dwells 1).
    function automatic logic [15:0] cnt_load(input int unsigned cycles);
        if (cycles == 0) begin
            return 16'd0;
        end
        return 16'(cycles - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tr_sequencer_gain_ramp.sv
`default_nettype none
// ============================================================================
// Module      : gain_ramp
// Description : Divider-paced +/-1 gain stepper toward a target, with compare.
// Revision    : 1.0  initial release
// ============================================================================
module gain_ramp #(
    parameter int unsigned RAMP_DIV = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run_i,
    input  logic [7:0] gain_i,
    input  logic [7:0] target_i,
    output logic [7:0] gain_o,
    output logic       at_target_o
);

    localparam logic [15:0] C_DIV_LAST = (RAMP_DIV == 0) ? 16'd0 : 16'(RAMP_DIV - 1);

    logic [15:0] div_q, div_d;
    logic        tick;

    assign at_target_o = (gain_i == target_i);
    assign tick        = (div_q == C_DIV_LAST);

    always_comb begin
        div_d  = div_q;
        gain_o = gain_i;
        if (!run_i || at_target_o) begin
            div_d = 16'd0;
        end else if (tick) begin
            div_d  = 16'd0;
            gain_o = (gain_i < target_i) ? gain_i + 8'd1 : gain_i - 8'd1;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_q <= 16'd0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tr_sequencer
// Description : Transmit/receive switch-over sequencer (mute, relay, gain ramp).
//               Define TR_RAMP_EN to build with paced gain ramping.
// Revision    : 1.0  initial release
// ============================================================================
module tr_sequencer
    import tr_seq_pkg::*;
#(
    parameter int unsigned RELAY_CYCLES = 2000,
    parameter int unsigned MUTE_CYCLES  = 200,
    parameter int unsigned RAMP_DIV     = 16,
    parameter int unsigned S_RATE_MAX   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ptt_req,
    input  logic [31:0] cfg_rx_freq,
    input  logic [31:0] cfg_tx_freq,
    input  logic [7:0]  cfg_s_rate,
    input  logic [7:0]  cfg_tx_level,
    output logic [31:0] rx_freq,
    output logic [31:0] tx_freq,
    output logic [7:0]  s_rate,
    output logic        rx_mute,
    output logic        rx_flush,
    output logic        relay_tx,
    output logic        tx_en,
    output logic [7:0]  tx_gain,
    output logic        busy
);

    localparam logic [15:0] C_MUTE_LOAD  = cnt_load(MUTE_CYCLES);
    localparam logic [15:0] C_RELAY_LOAD = cnt_load(RELAY_CYCLES);
    localparam logic [7:0]  C_S_RATE_MAX = 8'(S_RATE_MAX);

    tr_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rx_freq_q, rx_freq_d, tx_freq_q, tx_freq_d;
    logic [7:0]  s_rate_q, s_rate_d, gain_q, gain_d;
    logic        mute_q, mute_d, flush_q, flush_d, relay_q, relay_d;
    logic        tx_en_q, tx_en_d, busy_q, busy_d;
    logic        cnt_zero;

    assign cnt_zero = (cnt_q == 16'd0);

`ifdef TR_RAMP_EN
    logic       ramp_run, ramp_at_target;
    logic [7:0] ramp_target, ramp_gain;

    assign ramp_run    = (state_q == ST_RAMP_UP) || (state_q == ST_TX) || (state_q == ST_RAMP_DN);
    assign ramp_target = (state_q == ST_RAMP_DN) ? 8'd0 : cfg_tx_level;

    gain_ramp #(
        .RAMP_DIV    (RAMP_DIV)
    ) u_gain_ramp (
        .clock       (clock),
        .reset       (reset),
        .run_i       (ramp_run),
        .gain_i      (gain_q),
        .target_i    (ramp_target),
        .gain_o      (ramp_gain),
        .at_target_o (ramp_at_target)
    );
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RX:      if (ptt_req) state_d = ST_MUTE;
            ST_MUTE:    if (!ptt_req) state_d = ST_RX;
                        else if (cnt_zero) state_d = ST_RLY_ON;
            ST_RLY_ON:  if (!ptt_req) state_d = ST_RLY_OFF;
                        else if (cnt_zero) state_d = ST_RAMP_UP;
`ifdef TR_RAMP_EN
            ST_RAMP_UP: if (!ptt_req) state_d = ST_RAMP_DN;
                        else if (ramp_at_target) state_d = ST_TX;
            ST_RAMP_DN: if (ramp_at_target) state_d = ST_RLY_OFF;
`else
            ST_RAMP_UP: state_d = ptt_req ? ST_TX : ST_RAMP_DN;
            ST_RAMP_DN: state_d = ST_RLY_OFF;
`endif
            ST_TX:      if (!ptt_req) state_d = ST_RAMP_DN;
            ST_RLY_OFF: if (cnt_zero) state_d = ST_RX;
            default:    state_d = ST_RX;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                ST_MUTE:              cnt_d = C_MUTE_LOAD;
                ST_RLY_ON, ST_RLY_OFF: cnt_d = C_RELAY_LOAD;
                default:              cnt_d = 16'd0;
            endcase
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - 16'd1;
        end

        mute_d  = (state_d != ST_RX);
        busy_d  = (state_d != ST_RX);
        tx_en_d = (state_d == ST_RAMP_UP) || (state_d == ST_TX) || (state_d == ST_RAMP_DN);
        relay_d = tx_en_d || (state_d == ST_RLY_ON);

`ifdef TR_RAMP_EN
        gain_d = ramp_run ? ramp_gain : 8'd0;
`else
        case (state_q)
            ST_RAMP_UP: gain_d = (state_d == ST_TX) ? cfg_tx_level : 8'd0;
            ST_TX:      gain_d = cfg_tx_level;
            default:    gain_d = 8'd0;
        endcase
`endif

        rx_freq_d = (state_q == ST_RX) ? cfg_rx_freq : rx_freq_q;
        tx_freq_d = ((state_q == ST_RX) || (state_q == ST_MUTE)) ? cfg_tx_freq : tx_freq_q;

        // Rate changes held off outside RX fall through here on the first RX cycle.
        s_rate_d = s_rate_q;
        flush_d  = 1'b0;
        if ((state_q == ST_RX) && (cfg_s_rate != s_rate_q) && (cfg_s_rate <= C_S_RATE_MAX)) begin
            s_rate_d = cfg_s_rate;
            flush_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_RX;
            cnt_q     <= 16'd0;
            rx_freq_q <= C_RESET_FREQ;
            tx_freq_q <= C_RESET_FREQ;
            s_rate_q  <= C_S_RATE_50K;
            gain_q    <= 8'd0;
            mute_q    <= 1'b0;
            flush_q   <= 1'b0;
            relay_q   <= 1'b0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_freq_q <= rx_freq_d;
            tx_freq_q <= tx_freq_d;
            s_rate_q  <= s_rate_d;
            gain_q    <= gain_d;
            mute_q    <= mute_d;
            flush_q   <= flush_d;
            relay_q   <= relay_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_freq  = rx_freq_q;
    assign tx_freq  = tx_freq_q;
    assign s_rate   = s_rate_q;
    assign rx_mute  = mute_q;
    assign rx_flush = flush_q;
    assign relay_tx = relay_q;
    assign tx_en    = tx_en_q;
    assign tx_gain  = gain_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_tr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tr_sequencer
// Description : Directed self-checking bench for tr_sequencer (honours TR_RAMP_EN).
// Revision    : 1.0  initial release
// ============================================================================
module tb_tr_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ptt_req = 1'b0;
    logic [31:0] cfg_rx_freq = 32'd14_000_000;
    logic [31:0] cfg_tx_freq = 32'd10_000_000;
    logic [7:0]  cfg_s_rate = 8'd0;
    logic [7:0]  cfg_tx_level = 8'd0;
    logic [31:0] rx_freq, tx_freq;
    logic [7:0]  s_rate, tx_gain;
    logic        rx_mute, rx_flush, relay_tx, tx_en, busy;

    int passed = 0;
    int total  = 0;

    tr_sequencer #(
        .RELAY_CYCLES (20),
        .MUTE_CYCLES  (4),
        .RAMP_DIV     (2),
        .S_RATE_MAX   (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ptt_req      (ptt_req),
        .cfg_rx_freq  (cfg_rx_freq),
        .cfg_tx_freq  (cfg_tx_freq),
        .cfg_s_rate   (cfg_s_rate),
        .cfg_tx_level (cfg_tx_level),
        .rx_freq      (rx_freq),
        .tx_freq      (tx_freq),
        .s_rate       (s_rate),
        .rx_mute      (rx_mute),
        .rx_flush     (rx_flush),
        .relay_tx     (relay_tx),
        .tx_en        (tx_en),
        .tx_gain      (tx_gain),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step(2);
        total++; if (rx_freq !== 32'd7_000_000) $display("FAIL rst_rx_freq: got %0d want 7000000", rx_freq); else passed++;
        total++; if (tx_freq !== 32'd7_000_000) $display("FAIL rst_tx_freq: got %0d want 7000000", tx_freq); else passed++;
        total++; if ({s_rate, tx_gain} !== 16'h0000) $display("FAIL rst_rate_gain: got %h want 0000", {s_rate, tx_gain}); else passed++;
        total++; if ({rx_mute, rx_flush, relay_tx, tx_en, busy} !== 5'b0) $display("FAIL rst_flags: got %b want 00000", {rx_mute, rx_flush, relay_tx, tx_en, busy}); else passed++;
        reset = 1'b1;
        step(1);
        total++; if (rx_freq !== 32'd14_000_000) $display("FAIL rx_freq_load: got %0d want 14000000", rx_freq); else passed++;
        total++; if (tx_freq !== 32'd10_000_000) $display("FAIL tx_freq_load: got %0d want 10000000", tx_freq); else passed++;
    endtask

    task automatic test_s_rate();
        cfg_s_rate = 8'd2;
        step(1);
        total++; if ({s_rate, rx_flush} !== {8'd2, 1'b1}) $display("FAIL srate_upd: got %0d/%b want 2/1", s_rate, rx_flush); else passed++;
        step(1);
        total++; if (rx_flush !== 1'b0) $display("FAIL srate_one_pulse: got %b want 0", rx_flush); else passed++;
        cfg_s_rate = 8'd5;
        step(1);
        total++; if ({s_rate, rx_flush} !== {8'd2, 1'b0}) $display("FAIL srate_illegal: got %0d/%b want 2/0", s_rate, rx_flush); else passed++;
        step(1);
        total++; if ({s_rate, rx_flush} !== {8'd2, 1'b0}) $display("FAIL srate_illegal2: got %0d/%b want 2/0", s_rate, rx_flush); else passed++;
    endtask

    task automatic test_tx_cycle();
        cfg_tx_level = 8'd8;
        ptt_req = 1'b1;
        step(1);
        total++; if ({rx_mute, busy, relay_tx} !== 3'b110) $display("FAIL mute_entry: got %b want 110", {rx_mute, busy, relay_tx}); else passed++;
        step(3);
        total++; if (relay_tx !== 1'b0) $display("FAIL relay_early: got %b want 0", relay_tx); else passed++;
        step(1);
        total++; if ({relay_tx, tx_en} !== 2'b10) $display("FAIL relay_on: got %b want 10", {relay_tx, tx_en}); else passed++;
        step(19);
        total++; if (tx_en !== 1'b0) $display("FAIL tx_en_early: got %b want 0", tx_en); else passed++;
        step(1);
        total++; if ({tx_en, tx_gain} !== {1'b1, 8'd0}) $display("FAIL tx_en_on: got %b/%0d want 1/0", tx_en, tx_gain); else passed++;
`ifdef TR_RAMP_EN
        step(15);
        total++; if (tx_gain !== 8'd7) $display("FAIL ramp_up_mid: got %0d want 7", tx_gain); else passed++;
        step(1);
        total++; if (tx_gain !== 8'd8) $display("FAIL ramp_up_end: got %0d want 8", tx_gain); else passed++;
        step(1);
`else
        step(1);
        total++; if (tx_gain !== 8'd8) $display("FAIL gain_jump: got %0d want 8", tx_gain); else passed++;
`endif
        cfg_tx_freq = 32'd21_000_000;
        cfg_rx_freq = 32'd3_000_000;
        cfg_s_rate  = 8'd1;
        step(3);
        total++; if (tx_freq !== 32'd10_000_000) $display("FAIL tx_freq_frozen: got %0d want 10000000", tx_freq); else passed++;
        total++; if (rx_freq !== 32'd14_000_000) $display("FAIL rx_freq_held: got %0d want 14000000", rx_freq); else passed++;
        total++; if ({s_rate, rx_flush} !== {8'd2, 1'b0}) $display("FAIL srate_tx_held: got %0d/%b want 2/0", s_rate, rx_flush); else passed++;
        ptt_req = 1'b0;
        step(1);
        total++; if ({tx_en, tx_gain} !== {1'b1, 8'd8}) $display("FAIL ramp_dn_entry: got %b/%0d want 1/8", tx_en, tx_gain); else passed++;
`ifdef TR_RAMP_EN
        step(15);
        total++; if (tx_gain !== 8'd1) $display("FAIL ramp_dn_mid: got %0d want 1", tx_gain); else passed++;
        step(1);
        total++; if ({tx_gain, relay_tx} !== {8'd0, 1'b1}) $display("FAIL ramp_dn_end: got %0d/%b want 0/1", tx_gain, relay_tx); else passed++;
`endif
        step(1);
        total++; if ({relay_tx, tx_en, tx_gain, rx_mute} !== {2'b00, 8'd0, 1'b1}) $display("FAIL rly_off_entry: got %b want 00000000001", {relay_tx, tx_en, tx_gain, rx_mute}); else passed++;
        step(19);
        total++; if ({rx_mute, busy} !== 2'b11) $display("FAIL rly_off_hold: got %b want 11", {rx_mute, busy}); else passed++;
        step(1);
        total++; if ({rx_mute, busy} !== 2'b00) $display("FAIL rx_return: got %b want 00", {rx_mute, busy}); else passed++;
        step(1);
        total++; if (tx_freq !== 32'd21_000_000) $display("FAIL tx_freq_rx: got %0d want 21000000", tx_freq); else passed++;
        total++; if (rx_freq !== 32'd3_000_000) $display("FAIL rx_freq_rx: got %0d want 3000000", rx_freq); else passed++;
        total++; if ({s_rate, rx_flush} !== {8'd1, 1'b1}) $display("FAIL srate_pending: got %0d/%b want 1/1", s_rate, rx_flush); else passed++;
    endtask

    task automatic test_same_cycle();
        cfg_s_rate = 8'd0;
        ptt_req = 1'b1;
        step(1);
        total++; if ({rx_mute, busy, rx_flush, s_rate} !== {3'b111, 8'd0}) $display("FAIL ptt_and_flush: got %b/%0d want 111/0", {rx_mute, busy, rx_flush}, s_rate); else passed++;
        ptt_req = 1'b0;
        step(1);
        total++; if ({rx_mute, rx_flush} !== 2'b00) $display("FAIL ptt_and_flush_end: got %b want 00", {rx_mute, rx_flush}); else passed++;
    endtask

    task automatic test_mute_abort();
        ptt_req = 1'b1;
        step(2);
        total++; if ({rx_mute, relay_tx} !== 2'b10) $display("FAIL abort_in_mute: got %b want 10", {rx_mute, relay_tx}); else passed++;
        ptt_req = 1'b0;
        step(1);
        total++; if ({rx_mute, busy, relay_tx} !== 3'b000) $display("FAIL abort_to_rx: got %b want 000", {rx_mute, busy, relay_tx}); else passed++;
    endtask

    task automatic test_relay_abort();
        ptt_req = 1'b1;
        step(5);
        total++; if (relay_tx !== 1'b1) $display("FAIL abort_rly_on: got %b want 1", relay_tx); else passed++;
        step(5);
        ptt_req = 1'b0;
        step(1);
        total++; if ({relay_tx, busy, tx_en} !== 3'b010) $display("FAIL abort_rly_off: got %b want 010", {relay_tx, busy, tx_en}); else passed++;
        ptt_req = 1'b1;
        step(19);
        total++; if ({busy, rx_mute, relay_tx} !== 3'b110) $display("FAIL abort_hold: got %b want 110", {busy, rx_mute, relay_tx}); else passed++;
        step(1);
        total++; if ({busy, rx_mute} !== 2'b00) $display("FAIL abort_rx: got %b want 00", {busy, rx_mute}); else passed++;
        step(1);
        total++; if ({busy, rx_mute, relay_tx} !== 3'b110) $display("FAIL abort_remute: got %b want 110", {busy, rx_mute, relay_tx}); else passed++;
        ptt_req = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_ramp();
        cfg_s_rate = 8'd2;
        ptt_req = 1'b1;
        step(25);
        total++; if ({tx_en, relay_tx} !== 2'b11) $display("FAIL pre_reset_ramp: got %b want 11", {tx_en, relay_tx}); else passed++;
`ifdef TR_RAMP_EN
        step(5);
`endif
        reset = 1'b0;
        step(1);
        total++; if ({rx_freq, tx_freq} !== {32'd7_000_000, 32'd7_000_000}) $display("FAIL mid_rst_freq: got %0d/%0d want 7000000/7000000", rx_freq, tx_freq); else passed++;
        total++; if ({s_rate, tx_gain} !== 16'h0000) $display("FAIL mid_rst_rate_gain: got %h want 0000", {s_rate, tx_gain}); else passed++;
        total++; if ({rx_mute, rx_flush, relay_tx, tx_en, busy} !== 5'b0) $display("FAIL mid_rst_flags: got %b want 00000", {rx_mute, rx_flush, relay_tx, tx_en, busy}); else passed++;
        ptt_req = 1'b0;
        reset = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_s_rate();
        test_tx_cycle();
        test_same_cycle();
        test_mute_abort();
        test_relay_abort();
        test_reset_mid_ramp();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
